// File: rtl/eth_rx_filter.sv
// eth_rx_filter: strips FCS from the MAC receive stream, captures DA/EtherType and issues a good/bad verdict per frame.
module eth_rx_filter #(
  parameter int MIN_LEN     = 60,
  parameter int MAX_LEN     = 1514,
  parameter int STS_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cfg_mac_i,
  input  logic        cfg_promisc_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  input  logic        s_sof_i,
  input  logic        s_eof_i,
  input  logic        s_fr_good_i,
  input  logic        s_fr_err_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  output logic        m_sof_o,
  output logic        m_eof_o,
  output logic        m_good_o,
  output logic        m_bad_o,
  output logic        m_abort_o,
  output logic [47:0] dst_mac_o,
  output logic [15:0] eth_type_o,
  output logic [15:0] cnt_good_o,
  output logic [15:0] cnt_bad_o
);
  typedef enum logic [1:0] {IDLE, RECV, WAIT_STS} st_t;
  localparam logic [11:0] LEN_LO = 12'(MIN_LEN + 4);
  localparam logic [11:0] LEN_HI = 12'(MAX_LEN + 4);
  localparam logic [7:0]  TMO    = 8'(STS_TIMEOUT - 1);
  st_t             st_q, st_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [3:0][7:0] sr_q, sr_d;
  logic [3:0]      pv_q, pv_d, ps_q, ps_d;
  logic [47:0]     dst_q, dst_d;
  logic [15:0]     typ_q, typ_d;
  logic            ok_q, ok_d;
  logic [7:0]      tmr_q, tmr_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eof_q, m_eof_d;
  logic            m_good_q, m_good_d, m_bad_q, m_bad_d, m_abort_q, m_abort_d;
  logic [15:0]     cnt_good_q, cnt_good_d, cnt_bad_q, cnt_bad_d;
  logic            start, in_frame, emit, sts, sts_ok, match, len_ok, drop;
  logic [10:0]     k, nxt;
  always_comb begin
    start    = s_valid_i & s_sof_i;
    in_frame = st_q == RECV;
    sts      = s_fr_good_i | s_fr_err_i;
    sts_ok   = s_fr_good_i & ~s_fr_err_i;
    k        = start ? 11'd0 : cnt_q;
    nxt      = (k == 11'h7FF) ? k : k + 11'd1;
    match    = (dst_q == cfg_mac_i) | (&dst_q) | cfg_promisc_i;
    len_ok   = ({1'b0, nxt} >= LEN_LO) && ({1'b0, nxt} <= LEN_HI);
    emit     = s_valid_i & in_frame & ~s_sof_i & pv_q[3];
    st_d     = st_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    pv_d     = pv_q;
    ps_d     = ps_q;
    dst_d    = dst_q;
    typ_d    = typ_q;
    ok_d     = ok_q;
    tmr_d    = tmr_q;
    drop     = 1'b0;
    m_data_d  = emit ? sr_q[3] : 8'd0;
    m_valid_d = emit;
    m_sof_d   = emit & ps_q[3];
    m_eof_d   = emit & s_eof_i;
    m_good_d  = 1'b0;
    m_bad_d   = 1'b0;
    m_abort_d = s_valid_i & in_frame & s_sof_i;
    if (st_q == WAIT_STS) begin
      if (sts) begin
        m_good_d = sts_ok & ok_q;
        m_bad_d  = ~m_good_d;
        st_d     = IDLE;
      end else if (start) begin
        m_bad_d = 1'b1;
      end else if (tmr_q == TMO) begin
        m_bad_d = 1'b1;
        st_d    = IDLE;
      end else begin
        tmr_d = tmr_q + 8'd1;
      end
    end
    if (s_valid_i & (start | in_frame)) begin
      sr_d  = {sr_q[2:0], s_data_i};
      pv_d  = s_sof_i ? 4'b0001 : {pv_q[2:0], 1'b1};
      ps_d  = s_sof_i ? 4'b0001 : {ps_q[2:0], 1'b0};
      cnt_d = nxt;
      st_d  = RECV;
      dst_d = (k < 11'd6) ? {dst_q[39:0], s_data_i} : dst_q;
      typ_d = (k == 11'd12) ? {s_data_i, typ_q[7:0]} : (k == 11'd13) ? {typ_q[15:8], s_data_i} : typ_q;
      if (s_eof_i) begin
        pv_d = 4'b0000;
        st_d = IDLE;
        if (nxt <= 11'd4) begin
          drop = 1'b1;
        end else if (sts) begin
          m_good_d = sts_ok & len_ok & match;
          m_bad_d  = ~m_good_d;
        end else begin
          st_d  = WAIT_STS;
          ok_d  = len_ok & match;
          tmr_d = 8'd0;
        end
      end
    end
    cnt_good_d = (m_good_d && cnt_good_q != 16'hFFFF) ? cnt_good_q + 16'd1 : cnt_good_q;
    cnt_bad_d  = ((m_bad_d | m_abort_d | drop) && cnt_bad_q != 16'hFFFF) ? cnt_bad_q + 16'd1 : cnt_bad_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      pv_q       <= '0;
      ps_q       <= '0;
      dst_q      <= '0;
      typ_q      <= '0;
      ok_q       <= 1'b0;
      tmr_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      m_good_q   <= 1'b0;
      m_bad_q    <= 1'b0;
      m_abort_q  <= 1'b0;
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      pv_q       <= pv_d;
      ps_q       <= ps_d;
      dst_q      <= dst_d;
      typ_q      <= typ_d;
      ok_q       <= ok_d;
      tmr_q      <= tmr_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eof_q    <= m_eof_d;
      m_good_q   <= m_good_d;
      m_bad_q    <= m_bad_d;
      m_abort_q  <= m_abort_d;
      cnt_good_q <= cnt_good_d;
      cnt_bad_q  <= cnt_bad_d;
    end
  end
  assign m_data_o   = m_data_q;
  assign m_valid_o  = m_valid_q;
  assign m_sof_o    = m_sof_q;
  assign m_eof_o    = m_eof_q;
  assign m_good_o   = m_good_q;
  assign m_bad_o    = m_bad_q;
  assign m_abort_o  = m_abort_q;
  assign dst_mac_o  = dst_q;
  assign eth_type_o = typ_q;
  assign cnt_good_o = cnt_good_q;
  assign cnt_bad_o  = cnt_bad_q;
endmodule
